// File: rtl/jtag_mem_pkg.sv
// Shared types and constants for the JTAG-driven memory master.
package jtag_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int MAX_DATA_W = 256;
    localparam int CNT_W      = 16;

    // Returned on a timed-out access; sliced down to the instance data width.
    localparam logic [MAX_DATA_W-1:0] ERR_DATA = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/jtag_mem_master_if.sv
// Command, response and memory-bus signals of the JTAG memory master.
interface jtag_mem_master_if
    import jtag_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic              cmd_inc;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // View of the bus master itself.
    modport master (
        input  cmd_valid, cmd_wr, cmd_inc, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    // View of the surrounding command source, response sink and memory.
    modport slave (
        output cmd_valid, cmd_wr, cmd_inc, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/jtag_mem_master.sv
// One single-beat memory access per JTAG command, with an auto-increment pointer
// and a request/wait timeout that returns an error response.
module jtag_mem_master
    import jtag_mem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_STEP = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic               clk_p,
    input  logic               rst_top,
    jtag_mem_master_if.master  bus,
    output logic [ADDR_W-1:0]  cur_addr,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               complete;
    logic               expired;

    always_ff @(posedge clk_p or negedge rst_top) begin
        if (!rst_top) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        complete    = 1'b0;
        expired     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    mem_addr_d  = bus.cmd_inc ? ptr_q : bus.cmd_addr;
                    if (!bus.cmd_inc) begin
                        ptr_d = bus.cmd_addr;
                    end
                    mem_we_d    = bus.cmd_wr;
                    mem_wdata_d = bus.cmd_wdata;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ, WAIT: begin
                // A completion seen on the expiry cycle still wins over the timeout.
                complete = (state_q == REQ) ? (bus.mem_gnt && bus.mem_rvalid) : bus.mem_rvalid;
                expired  = (cnt_q == CNT_W'(TIMEOUT));
                cnt_d    = cnt_q + 1'b1;
                if (complete) begin
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = mem_we_q ? mem_wdata_q : bus.mem_rdata;
                    ptr_d       = mem_addr_q + ADDR_W'(ADDR_STEP);
                    state_d     = RESP;
                end else if (expired) begin
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = ERR_DATA[DATA_W-1:0];
                    state_d     = RESP;
                end else if (state_q == REQ && bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up with it.
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cur_addr      = ptr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_jtag_mem_master.sv
// Directed bench for jtag_mem_master: reads, burst writes, timeouts, backpressure,
// pointer wrap and asynchronous reset in each busy state.
module tb_jtag_mem_master;

    localparam int TO = 20;

    logic        clk_p;
    logic        rst_top;
    logic [31:0] cur_addr;
    logic        busy;
    int          n_checks = 0;
    int          n_errors = 0;

    jtag_mem_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    jtag_mem_master #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .ADDR_STEP(4),
        .TIMEOUT  (TO)
    ) dut (
        .clk_p   (clk_p),
        .rst_top (rst_top),
        .bus     (bus),
        .cur_addr(cur_addr),
        .busy    (busy)
    );

    initial clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic run_txn(input string tag, input bit wr, input bit inc,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int gnt_dly, input bit same, input int rv_dly,
                           input logic [31:0] rdata, input int rdy_dly, input bit noise,
                           input logic [31:0] exp_maddr, input logic [31:0] exp_rdata,
                           input logic [31:0] exp_ptr);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_inc   = inc;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        chk({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        tick();
        if (noise) begin
            bus.cmd_inc   = 1'b0;
            bus.cmd_addr  = 32'h0000_3000;
            bus.cmd_wdata = ~wdata;
            bus.cmd_wr    = ~wr;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            chk({tag, ".req"},       32'(bus.mem_req),   32'd1);
            chk({tag, ".mem_addr"},  bus.mem_addr,       exp_maddr);
            chk({tag, ".mem_we"},    32'(bus.mem_we),    32'(wr));
            if (wr) chk({tag, ".mem_wdata"}, bus.mem_wdata, wdata);
            chk({tag, ".ready_req"}, 32'(bus.cmd_ready), 32'd0);
            chk({tag, ".rsp_early"}, 32'(bus.rsp_valid), 32'd0);
            if (i == gnt_dly) begin
                bus.mem_gnt = 1'b1;
                if (same) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rdata;
                end
            end
            tick();
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (!same) begin
            for (int i = 0; i <= rv_dly; i++) begin
                chk({tag, ".req_wait"},  32'(bus.mem_req),   32'd0);
                chk({tag, ".rsp_wait"},  32'(bus.rsp_valid), 32'd0);
                chk({tag, ".busy_wait"}, 32'(busy),          32'd1);
                if (i == rv_dly) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rdata;
                end
                tick();
            end
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h5A5A_5A5A;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk({tag, ".rsp_valid"},  32'(bus.rsp_valid), 32'd1);
            chk({tag, ".rsp_rdata"},  bus.rsp_rdata,      exp_rdata);
            chk({tag, ".rsp_err"},    32'(bus.rsp_err),   32'd0);
            chk({tag, ".cur_addr"},   cur_addr,           exp_ptr);
            chk({tag, ".ready_rsp"},  32'(bus.cmd_ready), 32'd0);
            chk({tag, ".req_rsp"},    32'(bus.mem_req),   32'd0);
            chk({tag, ".addr_rsp"},   bus.mem_addr,       exp_maddr);
            if (i == rdy_dly) bus.rsp_ready = 1'b1;
            tick();
        end
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        chk({tag, ".rsp_done"},   32'(bus.rsp_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, ".busy_done"},  32'(busy),          32'd0);
        $display("txn %s: wr=%0d inc=%0d mem_addr=%08h rsp=%08h ptr=%08h",
                 tag, wr, inc, bus.mem_addr, bus.rsp_rdata, cur_addr);
    endtask

    // gnt_at < 0: never granted; otherwise granted in REQ cycle gnt_at (0-based).
    task automatic run_timeout(input string tag, input int gnt_at,
                               input logic [31:0] exp_maddr, input logic [31:0] exp_ptr);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b0;
        bus.cmd_inc   = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i <= TO; i++) begin
            chk({tag, ".rsp_early"}, 32'(bus.rsp_valid), 32'd0);
            chk({tag, ".req"},       32'(bus.mem_req),   32'((gnt_at < 0) || (i <= gnt_at)));
            bus.mem_gnt = (i == gnt_at);
            tick();
        end
        bus.mem_gnt = 1'b0;
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, ".rsp_err"},   32'(bus.rsp_err),   32'd1);
        chk({tag, ".rsp_rdata"}, bus.rsp_rdata,      32'hFFFF_FFFF);
        chk({tag, ".req_off"},   32'(bus.mem_req),   32'd0);
        chk({tag, ".mem_addr"},  bus.mem_addr,       exp_maddr);
        chk({tag, ".cur_addr"},  cur_addr,           exp_ptr);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, ".rsp_done"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".ready"},    32'(bus.cmd_ready), 32'd1);
        $display("txn %s: timeout err=%0d rsp=%08h ptr=%08h", tag, bus.rsp_err, bus.rsp_rdata, cur_addr);
    endtask

    // phase 0=REQ, 1=WAIT, 2=RESP; reset is pulsed mid-cycle with no clock edge.
    task automatic abort_at(input string tag, input int phase);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b0;
        bus.cmd_inc   = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        if (phase >= 1) begin bus.mem_gnt = 1'b1; tick(); bus.mem_gnt = 1'b0; end
        if (phase >= 2) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_0000; tick(); bus.mem_rvalid = 1'b0; end
        chk({tag, ".pre_req"}, 32'(bus.mem_req),   32'(phase == 0));
        chk({tag, ".pre_rsp"}, 32'(bus.rsp_valid), 32'(phase == 2));
        #2 rst_top = 1'b0;
        #1;
        chk({tag, ".req"},      32'(bus.mem_req),   32'd0);
        chk({tag, ".rsp"},      32'(bus.rsp_valid), 32'd0);
        chk({tag, ".ready"},    32'(bus.cmd_ready), 32'd1);
        chk({tag, ".cur_addr"}, cur_addr,           32'd0);
        chk({tag, ".busy"},     32'(busy),          32'd0);
        #2 rst_top = 1'b1;
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_gnt    = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt    = 1'b0;
        tick();
        chk({tag, ".stray_busy"}, 32'(busy),          32'd0);
        chk({tag, ".stray_rsp"},  32'(bus.rsp_valid), 32'd0);
        chk({tag, ".stray_ptr"},  cur_addr,           32'd0);
        $display("txn %s: reset in phase %0d, ptr=%08h", tag, phase, cur_addr);
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_wr     = 1'b0;
        bus.cmd_inc    = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        rst_top        = 1'b1;
        #2 rst_top = 1'b0;
        #1;
        chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("rst.rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst.mem_req",   32'(bus.mem_req),   32'd0);
        chk("rst.mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst.mem_addr",  bus.mem_addr,       32'd0);
        chk("rst.mem_wdata", bus.mem_wdata,      32'd0);
        chk("rst.cur_addr",  cur_addr,           32'd0);
        chk("rst.busy",      32'(busy),          32'd0);
        repeat (2) @(posedge clk_p);
        #3 rst_top = 1'b1;
        tick();

        // tag, wr, inc, addr, wdata, gnt_dly, same, rv_dly, rdata, rdy_dly, noise, exp_maddr, exp_rdata, exp_ptr
        run_txn("T1",   1'b0, 1'b0, 32'h0000_0100, 32'h0, 0, 1'b0, 0, 32'hCAFE_F00D, 0, 1'b0,
                32'h0000_0100, 32'hCAFE_F00D, 32'h0000_0104);
        run_txn("T2a",  1'b1, 1'b0, 32'h0000_01FC, 32'h11, 0, 1'b0, 0, 32'hBAD0_0001, 0, 1'b0,
                32'h0000_01FC, 32'h0000_0011, 32'h0000_0200);
        run_txn("T2b",  1'b1, 1'b1, 32'h0000_0FFF, 32'h22, 1, 1'b0, 2, 32'hBAD0_0002, 1, 1'b0,
                32'h0000_0200, 32'h0000_0022, 32'h0000_0204);
        run_txn("T2c",  1'b1, 1'b1, 32'h0000_0FFF, 32'h33, 0, 1'b0, 1, 32'hBAD0_0003, 0, 1'b0,
                32'h0000_0204, 32'h0000_0033, 32'h0000_0208);

        run_timeout("T3a", -1, 32'h0000_0208, 32'h0000_0208);
        run_timeout("T3b",  3, 32'h0000_0208, 32'h0000_0208);
        run_txn("T3c",  1'b0, 1'b1, 32'h0, 32'h0, 0, 1'b0, TO-1, 32'h1234_5678, 0, 1'b0,
                32'h0000_0208, 32'h1234_5678, 32'h0000_020C);
        run_txn("T3d",  1'b0, 1'b1, 32'h0, 32'h0, TO, 1'b1, 0, 32'h8765_4321, 0, 1'b0,
                32'h0000_020C, 32'h8765_4321, 32'h0000_0210);

        // Bus strobes while idle must not start or disturb anything.
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        tick();
        chk("idle.busy",     32'(busy),          32'd0);
        chk("idle.rsp",      32'(bus.rsp_valid), 32'd0);
        chk("idle.req",      32'(bus.mem_req),   32'd0);
        chk("idle.cur_addr", cur_addr,           32'h0000_0210);
        $display("txn idle: stray gnt/rvalid ignored, ptr=%08h", cur_addr);

        run_txn("T4",   1'b1, 1'b0, 32'h0000_0400, 32'hA5A5_0F0F, 5, 1'b0, 0, 32'hDEAD_0004, 4, 1'b1,
                32'h0000_0400, 32'hA5A5_0F0F, 32'h0000_0404);

        run_txn("T5a",  1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 0, 1'b0, 0, 32'h0000_0001, 0, 1'b0,
                32'hFFFF_FFF8, 32'h0000_0001, 32'hFFFF_FFFC);
        run_txn("T5b",  1'b0, 1'b1, 32'h0, 32'h0, 0, 1'b1, 0, 32'h0BAD_F00D, 0, 1'b0,
                32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0000_0000);

        for (int p = 0; p < 3; p++) begin
            run_txn("T6ld", 1'b0, 1'b0, 32'h0000_0800, 32'h0, 0, 1'b0, 0, 32'h0000_0800, 0, 1'b0,
                    32'h0000_0800, 32'h0000_0800, 32'h0000_0804);
            abort_at($sformatf("T6p%0d", p), p);
        end
        run_txn("T6post", 1'b0, 1'b1, 32'h0, 32'h0, 0, 1'b0, 0, 32'h600D_600D, 0, 1'b0,
                32'h0000_0000, 32'h600D_600D, 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
